// File: rtl/conv_encoder.sv
// conv_encoder: rate-1/2 feed-forward convolutional encoder.
// Serial information bits in, 2-bit code symbols {g0 parity, g1 parity} out.
// Both sides use valid/ready handshakes, and there is one registered output stage.
// Every frame starts in trellis state 0.
//
// Optional feature macro: CONV_ENC_TAIL_FLUSH_EN
//   defined   : after din_last, K-1 zero tail bits are encoded (FLUSH state).
//               This returns the trellis to state 0. enc_last marks the final tail symbol.
//   undefined : no tail. enc_last marks the symbol of the din_last bit.
//               The shift register is cleared on that accept.
//
// Legal constraint lengths are K = 3..7. G0/G1 are K bits wide.
// Their MSB taps the current input bit.
module conv_encoder #(
  parameter int           K  = 3,
  parameter logic [K-1:0] G0 = 3'b111,
  parameter logic [K-1:0] G1 = 3'b101
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       din,
  input  logic       din_valid,
  input  logic       din_last,
  output logic       din_ready,
  output logic [1:0] enc_data,
  output logic       enc_valid,
  output logic       enc_last,
  input  logic       enc_ready,
  output logic       busy
);

`ifdef CONV_ENC_TAIL_FLUSH_EN
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH} state_t;
  // Index of the final tail step; K <= 7 keeps it within 3 bits.
  localparam logic [2:0] FLUSH_LAST = 3'(K - 2);
`else
  typedef enum logic [0:0] {S_IDLE, S_RUN} state_t;
`endif

  state_t       state;
  logic [K-2:0] sr;          // trellis state; sr[K-2] is the most recent bit
`ifdef CONV_ENC_TAIL_FLUSH_EN
  logic [2:0]   flush_cnt;   // tail step index 0..K-2
`endif

  logic         out_free;    // output register can take a new symbol this cycle
  logic         in_flush;
  logic         accept;      // information bit handshake completes
  logic         flush_step;  // a tail bit is encoded this cycle
  logic         bit_in;      // bit entering the encoder (data or zero tail)
  logic [K-1:0] taps;
  logic [1:0]   parity;
  logic         sym_last;    // symbol being loaded closes the frame

  assign out_free = !enc_valid || enc_ready;

`ifdef CONV_ENC_TAIL_FLUSH_EN
  assign in_flush   = (state == S_FLUSH);
  assign flush_step = in_flush && out_free;
  assign sym_last   = flush_step && (flush_cnt == FLUSH_LAST);
`else
  assign in_flush   = 1'b0;
  assign flush_step = 1'b0;
  assign sym_last   = din_last;
`endif

  assign din_ready = !in_flush && out_free;
  assign accept    = din_valid && din_ready;
  assign bit_in    = flush_step ? 1'b0 : din;
  assign busy      = (state != S_IDLE) || enc_valid;

  // Generator parities over the tap vector {current bit, trellis state}.
  always_comb begin
    // NOTE: every signal driven here is assigned on all paths, so no latch is inferred.
    taps   = {bit_in, sr};
    parity = {^(taps & G0), ^(taps & G1)};
  end

  // Output register: load on an encode, hold under backpressure, drop valid once consumed.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every register reading pre-edge values.
    if (rst) begin
      enc_data  <= '0;
      enc_valid <= 1'b0;
      enc_last  <= 1'b0;
    end else if (accept || flush_step) begin
      enc_data  <= parity;
      enc_valid <= 1'b1;
      enc_last  <= sym_last;
    end else if (enc_ready) begin
      enc_valid <= 1'b0;
      enc_last  <= 1'b0;
    end
  end

`ifdef CONV_ENC_TAIL_FLUSH_EN
  // Frame FSM with trellis shift register and tail counter.
  // The tail counter and register freeze while the output stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      sr        <= '0;
      flush_cnt <= '0;
    end else begin
      unique case (state)
        S_IDLE, S_RUN: begin
          if (accept) begin
            sr        <= {din, sr[K-2:1]};
            flush_cnt <= '0;
            state     <= din_last ? S_FLUSH : S_RUN;
          end
        end
        S_FLUSH: begin
          if (flush_step) begin
            // Shifting in K-1 zeros leaves sr = 0 when the tail completes.
            sr <= {1'b0, sr[K-2:1]};
            if (flush_cnt == FLUSH_LAST) begin
              flush_cnt <= '0;
              state     <= S_IDLE;
            end else begin
              flush_cnt <= flush_cnt + 3'd1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
`else
  // Frame tracking and trellis shift register.
  // The register is cleared on the last bit, so the next frame starts in state 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      sr    <= '0;
    end else if (accept) begin
      if (din_last) begin
        sr    <= '0;
        state <= S_IDLE;
      end else begin
        sr    <= {din, sr[K-2:1]};
        state <= S_RUN;
      end
    end
  end
`endif

endmodule

// File: tb/tb_conv_encoder.sv
// tb_conv_encoder: table-driven directed vectors for the framing corner cases.
// Randomized framed traffic is checked against a convolution reference model.
// The tail/no-tail behaviour follows CONV_ENC_TAIL_FLUSH_EN, as in the design.
module tb_conv_encoder;

  localparam int           K  = 3;
  localparam logic [K-1:0] G0 = 3'b111;
  localparam logic [K-1:0] G1 = 3'b101;
`ifdef CONV_ENC_TAIL_FLUSH_EN
  localparam int TAILN = K - 1;
`else
  localparam int TAILN = 0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       din, din_valid, din_last, din_ready;
  logic [1:0] enc_data;
  logic       enc_valid, enc_last, enc_ready, busy;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int rmode    = 0;          // 0: fixed ready pattern 1,0,0,1; 1: random
  logic [3:0] pat = 4'b1001;

  always #5 clk = ~clk;

  conv_encoder #(.K(K), .G0(G0), .G1(G1)) dut (
    .clk(clk), .rst(rst),
    .din(din), .din_valid(din_valid), .din_last(din_last), .din_ready(din_ready),
    .enc_data(enc_data), .enc_valid(enc_valid), .enc_last(enc_last),
    .enc_ready(enc_ready), .busy(busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model / scoreboard ----------------
  bit         cur_bits[$];
  logic [2:0] exp_q[$];      // {last, g0, g1}
  logic [2:0] got_q[$];
  int         len_q[$];

  // Each symbol is the convolution of the zero-padded frame with the generators.
  task automatic model_frame();
    int n, t;
    logic [K-1:0] g0v, g1v;
    g0v = G0;
    g1v = G1;
    n = cur_bits.size();
    t = n + TAILN;
    for (int i = 0; i < t; i++) begin
      bit s1, s0;
      s1 = 1'b0;
      s0 = 1'b0;
      for (int j = 0; j < K; j++) begin
        int idx;
        bit u;
        idx = i - j;
        u = (idx >= 0 && idx < n) ? cur_bits[idx] : 1'b0;
        s1 ^= g0v[K-1-j] & u;
        s0 ^= g1v[K-1-j] & u;
      end
      exp_q.push_back({(i == t - 1), s1, s0});
    end
    len_q.push_back(n);
    cur_bits.delete();
  endtask

  task automatic clear_sb();
    cur_bits.delete();
    exp_q.delete();
    got_q.delete();
    len_q.delete();
  endtask

  // Monitor at the falling edge: capture handshakes and check stall stability.
  bit         prev_stall = 1'b0;
  logic [1:0] prev_data;
  logic       prev_last;
  always @(negedge clk) begin
    if (rst) begin
      cur_bits.delete();
    end else begin
      if (prev_stall) begin
        check("stall_valid", enc_valid, 1);
        check("stall_data", enc_data, prev_data);
        check("stall_last", enc_last, prev_last);
      end
      if (enc_valid && !enc_ready) check("stall_din_ready", din_ready, 0);
      if (din_valid && din_ready) begin
        cur_bits.push_back(din);
        if (din_last) model_frame();
      end
      if (enc_valid && enc_ready) got_q.push_back({enc_last, enc_data});
    end
    prev_stall = !rst && enc_valid && !enc_ready;
    prev_data  = enc_data;
    prev_last  = enc_last;
  end

  // ---------------- drivers ----------------
  function automatic bit next_rdy();
    if (rmode == 1) return ($urandom_range(0, 4) != 0);
    return pat[cyc % 4];
  endfunction

  task automatic drive_cycle(input bit d, input bit v, input bit l, input bit r, output bit acc);
    din = d; din_valid = v; din_last = l; enc_ready = r;
    @(negedge clk);
    acc = din_valid && din_ready;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  bit fr_bits[$];

  task automatic send_frame();
    for (int i = 0; i < fr_bits.size(); i++) begin
      bit acc, v;
      int tries;
      acc = 1'b0;
      tries = 0;
      while (!acc && tries < 500) begin
        v = (rmode == 1) ? ($urandom_range(0, 9) != 0) : 1'b1;
        if (v) drive_cycle(fr_bits[i], 1'b1, (i == fr_bits.size() - 1), next_rdy(), acc);
        else   drive_cycle(1'($urandom), 1'b0, 1'($urandom), next_rdy(), acc);
        tries++;
      end
      if (!acc) begin
        check("accept_timeout", acc, 1);
        return;
      end
    end
  endtask

  task automatic drain();
    bit acc;
    int n;
    n = 0;
    while (busy && n < 300) begin
      drive_cycle(1'b0, 1'b0, 1'b0, next_rdy(), acc);
      n++;
    end
    check("drain_busy", busy, 0);
  endtask

  task automatic compare_streams();
    int m, f, cnt;
    check("stream_len", got_q.size(), exp_q.size());
    m = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < m; i++) check($sformatf("sym%0d", i), got_q[i], exp_q[i]);
    f = 0;
    cnt = 0;
    for (int i = 0; i < got_q.size(); i++) begin
      cnt++;
      if (got_q[i][2]) begin
        if (f < len_q.size()) check($sformatf("frame%0d_len", f), cnt, len_q[f] + TAILN);
        f++;
        cnt = 0;
      end
    end
    check("frame_count", f, len_q.size());
  endtask

  // ---------------- table-driven vectors ----------------
  typedef struct {
    string      name;
    bit         r, d, v, l, rdy;
    bit         exp_rdy;
    logic [1:0] exp_data;
    bit         exp_valid, exp_last, exp_busy;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input string nm, input bit r, input bit d, input bit v, input bit l,
                     input bit rdy, input bit erd, input logic [1:0] ed,
                     input bit ev, input bit el, input bit eb);
    vec_t t;
    t.name = nm; t.r = r; t.d = d; t.v = v; t.l = l; t.rdy = rdy;
    t.exp_rdy = erd; t.exp_data = ed; t.exp_valid = ev; t.exp_last = el; t.exp_busy = eb;
    tbl.push_back(t);
  endtask

  task automatic run_tbl();
    for (int i = 0; i < tbl.size(); i++) begin
      rst = tbl[i].r; din = tbl[i].d; din_valid = tbl[i].v; din_last = tbl[i].l;
      enc_ready = tbl[i].rdy;
      @(negedge clk);
      check({tbl[i].name, "_din_ready"}, din_ready, tbl[i].exp_rdy);
      @(posedge clk);
      #1;
      check({tbl[i].name, "_valid"}, enc_valid, tbl[i].exp_valid);
      check({tbl[i].name, "_last"}, enc_last, tbl[i].exp_last);
      check({tbl[i].name, "_busy"}, busy, tbl[i].exp_busy);
      if (tbl[i].exp_valid || tbl[i].r) check({tbl[i].name, "_data"}, enc_data, tbl[i].exp_data);
    end
    rst = 1'b0;
    tbl.delete();
  endtask

  // Overall time bound.
  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] bp_exp[$];
    rst = 1'b1; din = 1'b0; din_valid = 1'b0; din_last = 1'b0; enc_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_valid", enc_valid, 0);
    check("reset_data", enc_data, 0);
    check("reset_last", enc_last, 0);
    check("reset_busy", busy, 0);

`ifdef CONV_ENC_TAIL_FLUSH_EN
    // Basic frame 1,0,1,1 with a two-symbol tail.
    // Bits offered during FLUSH must be ignored.
    add("bas0", 0, 1, 1, 0, 1, 1, 2'b11, 1, 0, 1);
    add("bas1", 0, 0, 1, 0, 1, 1, 2'b10, 1, 0, 1);
    add("bas2", 0, 1, 1, 0, 1, 1, 2'b00, 1, 0, 1);
    add("bas3", 0, 1, 1, 1, 1, 1, 2'b01, 1, 0, 1);
    add("bas4", 0, 1, 1, 0, 1, 0, 2'b01, 1, 0, 1);
    add("bas5", 0, 0, 0, 1, 1, 0, 2'b11, 1, 1, 1);
    add("bas6", 0, 1, 0, 1, 1, 1, 2'b00, 0, 0, 0);
    // One-bit frame, then a back-to-back second one-bit frame.
    add("one0", 0, 1, 1, 1, 1, 1, 2'b11, 1, 0, 1);
    add("one1", 0, 0, 0, 0, 1, 0, 2'b10, 1, 0, 1);
    add("one2", 0, 0, 0, 0, 1, 0, 2'b11, 1, 1, 1);
    add("one3", 0, 0, 1, 1, 1, 1, 2'b00, 1, 0, 1);
    add("one4", 0, 0, 0, 0, 1, 0, 2'b00, 1, 0, 1);
    add("one5", 0, 0, 0, 0, 1, 0, 2'b00, 1, 1, 1);
    add("one6", 0, 0, 0, 0, 1, 1, 2'b00, 0, 0, 0);
    // Reset after the fifth symbol, then a fresh one-bit frame.
    add("rs0", 0, 1, 1, 0, 1, 1, 2'b11, 1, 0, 1);
    add("rs1", 0, 0, 1, 0, 1, 1, 2'b10, 1, 0, 1);
    add("rs2", 0, 1, 1, 0, 1, 1, 2'b00, 1, 0, 1);
    add("rs3", 0, 1, 1, 1, 1, 1, 2'b01, 1, 0, 1);
    add("rs4", 0, 0, 0, 0, 1, 0, 2'b01, 1, 0, 1);
    add("rs5", 1, 0, 0, 0, 1, 0, 2'b00, 0, 0, 0);
    add("rs6", 0, 1, 1, 1, 1, 1, 2'b11, 1, 0, 1);
    add("rs7", 0, 0, 0, 0, 1, 0, 2'b10, 1, 0, 1);
    add("rs8", 0, 0, 0, 0, 1, 0, 2'b11, 1, 1, 1);
    add("rs9", 0, 0, 0, 0, 1, 1, 2'b00, 0, 0, 0);
    bp_exp = '{3'b011, 3'b010, 3'b000, 3'b001, 3'b001, 3'b111};
`else
    // Frame 1,0,1,1 with no tail, then a one-bit frame that must start from state 0.
    add("nb0", 0, 1, 1, 0, 1, 1, 2'b11, 1, 0, 1);
    add("nb1", 0, 0, 1, 0, 1, 1, 2'b10, 1, 0, 1);
    add("nb2", 0, 1, 1, 0, 1, 1, 2'b00, 1, 0, 1);
    add("nb3", 0, 1, 1, 1, 1, 1, 2'b01, 1, 1, 1);
    add("nb4", 0, 1, 1, 1, 1, 1, 2'b11, 1, 1, 1);
    add("nb5", 0, 1, 0, 1, 1, 1, 2'b00, 0, 0, 0);
    // Reset mid-frame discards history; the next one-bit frame gives 11.
    add("nr0", 0, 1, 1, 0, 1, 1, 2'b11, 1, 0, 1);
    add("nr1", 0, 0, 1, 0, 1, 1, 2'b10, 1, 0, 1);
    add("nr2", 1, 1, 1, 0, 1, 1, 2'b00, 0, 0, 0);
    add("nr3", 0, 1, 1, 1, 1, 1, 2'b11, 1, 1, 1);
    add("nr4", 0, 0, 0, 0, 1, 1, 2'b00, 0, 0, 0);
    bp_exp = '{3'b011, 3'b010, 3'b000, 3'b101};
`endif
    run_tbl();

    // Backpressure: same frame with enc_ready following 1,0,0,1,...
    clear_sb();
    rmode = 0;
    cyc = 0;
    fr_bits = '{1'b1, 1'b0, 1'b1, 1'b1};
    send_frame();
    drain();
    check("bp_count", got_q.size(), bp_exp.size());
    for (int i = 0; i < bp_exp.size() && i < got_q.size(); i++)
      check($sformatf("bp_sym%0d", i), got_q[i], bp_exp[i]);
    compare_streams();

    // Random frames with random valid and ready.
    clear_sb();
    rmode = 1;
    for (int f = 0; f < 1000; f++) begin
      int n;
      n = $urandom_range(1, 64);
      fr_bits.delete();
      for (int i = 0; i < n; i++) fr_bits.push_back(1'($urandom));
      send_frame();
    end
    drain();
    check("rand_frames", len_q.size(), 1000);
    compare_streams();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
